muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
//
// PURPOSE
// Iterative multiply/divide unit with its controlling FSM, owning the HI/LO registers for
// MULT/MULTU/DIV/DIVU/MTHI/MTLO. Sits beside the ALU in EX and takes the same a/b operands.
// Holds busy while iterating; the hazard unit stalls any MFHI/MFLO/mul/div until busy falls.
// Processes one result bit per cycle, so no wide multiplier array is needed.
//
// PARAMETERS
// WIDTH   32   operand, HI and LO width
//
// PORTS
// clk        in   1      rising-edge clock
// rstN       in   1      asynchronous active-low reset
// start      in   1      launch op; sampled only in IDLE
// op         in   2      mdOp_t: MULT=00 MULTU=01 DIV=10 DIVU=11
// a          in   WIDTH  multiplicand / dividend
// b          in   WIDTH  multiplier / divisor
// flush      in   1      synchronous abort (branch mispredict / exception)
// hiWe       in   1      MTHI write enable
// loWe       in   1      MTLO write enable
// wrData     in   WIDTH  MTHI/MTLO data
// busy       out  1      operation in flight
// done       out  1      one-cycle pulse; new HI/LO visible this cycle
// divByZero  out  1      valid with done; set when a DIV/DIVU had b==0
// hi         out  WIDTH  HI register
// lo         out  WIDTH  LO register
//
// BEHAVIOUR
// - Reset (async, rstN=0): state=IDLE, hi=0, lo=0, busy=0, done=0, divByZero=0, counter=0.
// - States: IDLE -> PREP -> ITER (WIDTH cycles) -> FIXUP -> IDLE.
//   busy=1 in PREP/ITER/FIXUP. done is registered and high in the first IDLE cycle after FIXUP.
// - Latency: start seen at edge 0. PREP runs in cycle 1 and ITER in cycles 2..WIDTH+1.
//   FIXUP runs in cycle WIDTH+2. done=1 in cycle WIDTH+3 (35 for WIDTH=32).
//   A new start is accepted in the done cycle.
// - PREP latches the op and converts signed operands to unsigned magnitudes (MULT/DIV only).
//   It also latches the signs and loads counter=WIDTH.
// - Multiply ITER: shift-add over a 2*WIDTH accumulator.
//   FIXUP negates the 2*WIDTH product if sign(a)^sign(b). hi=product[2W-1:W], lo=product[W-1:0].
// - Divide ITER: restoring shift-subtract. lo=quotient, hi=remainder.
//   Quotient is negated if sign(a)^sign(b); remainder takes the dividend's sign.
//   0x8000_0000 / -1 gives lo=0x8000_0000, hi=0, with no trap.
// - Divide by zero is detected in PREP. The FSM then skips ITER and FIXUP and returns to IDLE:
//   hi=a, lo={WIDTH{1}}, divByZero=1, done in cycle 2.
// - divByZero clears on the next done or on reset.
// - start while busy: ignored, with no queueing.
// - flush: at the next edge goes to IDLE, busy=0. No done, HI/LO untouched.
//   flush has priority over start and over FIXUP's writeback in the same cycle.
// - hiWe/loWe: take effect only when busy=0 (writes while busy are dropped; the pipeline stalls).
//   In IDLE alongside start, the write happens and the later result overwrites it.
// - Reset mid-operation: immediate return to reset values; any partial result is discarded.
//
// STRUCTURE
// - Package muldiv_pkg holds:
//   - typedef enum logic [1:0] mdOp_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}
//   - typedef enum mdState_t {ST_IDLE, ST_PREP, ST_ITER, ST_FIXUP}
// - Counter width is $clog2(WIDTH)+1.
// - Sub-module muldiv_step (combinational) performs one iteration: conditional add for multiply,
//   trial subtract for divide. The FSM, counters and HI/LO registers live in this module.
//
// TESTING
// 1. MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> hi=FFFF_FFFE, lo=0000_0001; done exactly 35 cycles
//    after start; busy high 34 cycles.
// 2. MULT -7*3 -> hi=FFFF_FFFF, lo=FFFF_FFEB. MULT 0x8000_0000*-1 -> hi=0, lo=8000_0000.
// 3. DIV -7/2 -> lo=FFFF_FFFD, hi=FFFF_FFFF. DIVU 7/2 -> lo=3, hi=1.
//    DIV 0x8000_0000/-1 -> lo=8000_0000, hi=0.
// 4. DIVU 5/0 -> done in cycle 2, divByZero=1, hi=5, lo=FFFF_FFFF.
//    The following MULTU 2*3 -> divByZero=0, lo=6.
// 5. MTLO 0x1234 then MULT with flush in cycle 10 -> busy=0 in cycle 11, no done, lo=0x1234.
//    Start and hiWe in the busy window are ignored.
// 6. rstN low in cycle 20 of DIV -> hi/lo/busy/done=0 immediately.
//    Back-to-back start in the done cycle runs the second op with correct results.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// sequencer states and a small helper that classifies signed operations.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PREP  = 2'b01,
        ST_ITER  = 2'b10,
        ST_FIXUP = 2'b11
    } mdState_t;

    // MULT and DIV treat operands as two's complement; the U variants do not.
    function automatic logic md_is_signed(input mdOp_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Divide operations share op[1] = 1.
    function automatic logic md_is_div(input mdOp_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath, purely combinational.
// Multiply: accumulator is {partial product, remaining multiplier bits};
//   add the multiplicand into the upper half when the current multiplier bit
//   is set, then shift the whole accumulator right by one.
// Divide: accumulator is {partial remainder, remaining dividend / quotient};
//   shift left by one, trial-subtract the divisor from the upper half and keep
//   the difference (quotient bit 1) only when it did not go negative.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_isDiv,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_remSh;
    logic [WIDTH:0] w_trial;

    // Select between the shift-add and the restoring shift-subtract step.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_remSh = i_acc[2*WIDTH-1:WIDTH-1];
        w_trial = w_remSh - {1'b0, i_operand};
        if (i_isDiv) begin
            if (w_trial[WIDTH]) begin
                o_acc = {w_remSh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end else begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Handshake: start is accepted only while busy=0 (IDLE); once accepted, busy
// stays high until the result is written, and done pulses for exactly one
// cycle with the new HI/LO already visible. A start seen while busy is
// dropped, not queued. flush aborts at the next edge without a done pulse.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output mdState_t         dbgState
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdState_t           r_state;
    mdOp_t              r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signA;
    logic               r_signB;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_isSigned;
    logic               w_isDiv;
    logic               w_divZero;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [2*WIDTH-1:0] w_stepAcc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_isDiv   (w_isDiv),
        .o_acc     (w_stepAcc)
    );

    // Operand magnitudes for PREP and sign correction of the raw result for FIXUP.
    always_comb begin
        w_isSigned = md_is_signed(r_op);
        w_isDiv    = md_is_div(r_op);
        w_divZero  = w_isDiv && (r_b == '0);
        w_magA     = (w_isSigned && r_a[WIDTH-1]) ? -r_a : r_a;
        w_magB     = (w_isSigned && r_b[WIDTH-1]) ? -r_b : r_b;
        // Signs are latched as zero for unsigned ops, so no extra qualification here.
        w_prod     = (r_signA ^ r_signB) ? -r_acc : r_acc;
        w_quo      = (r_signA ^ r_signB) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem      = r_signA ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fixHi    = w_isDiv ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_fixLo    = w_isDiv ? w_quo : w_prod[WIDTH-1:0];
    end

    // Sequencer FSM, iteration datapath and HI/LO ownership.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= ST_IDLE;
            r_op      <= MD_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // MTHI/MTLO land only while idle; a result written later overwrites them.
            if (r_state == ST_IDLE) begin
                if (hiWe) r_hi <= wrData;
                if (loWe) r_lo <= wrData;
            end

            if (flush) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_op    <= mdOp_t'(op);
                            r_a     <= a;
                            r_b     <= b;
                            r_busy  <= 1'b1;
                            r_state <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        if (w_divZero) begin
                            // No iteration: dividend to HI, all ones to LO, flagged.
                            r_hi    <= r_a;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_signA <= w_isSigned && r_a[WIDTH-1];
                            r_signB <= w_isSigned && r_b[WIDTH-1];
                            r_cnt   <= CW'(WIDTH);
                            if (w_isDiv) begin
                                r_acc     <= {{WIDTH{1'b0}}, w_magA};
                                r_operand <= w_magB;
                            end else begin
                                r_acc     <= {{WIDTH{1'b0}}, w_magB};
                                r_operand <= w_magA;
                            end
                            r_state <= ST_ITER;
                        end
                    end
                    ST_ITER: begin
                        r_acc <= w_stepAcc;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= ST_FIXUP;
                        end
                    end
                    ST_FIXUP: begin
                        r_hi    <= w_fixHi;
                        r_lo    <= w_fixLo;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbgState  = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of operations with
// hand-computed HI/LO/divByZero/latency, then flush, reset and back-to-back
// sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hiWe;
  logic        loWe;
  logic [31:0] wrData;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;
  mdState_t    dbgState;

  int n_vec = 0;
  int n_err = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .hiWe      (hiWe),
    .loWe      (loWe),
    .wrData    (wrData),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo),
    .dbgState  (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          elat;
    int          ebusy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drives start at the current time (mid-cycle), returns #1 after the edge
  // that raised done (or after the cycle budget, with lat = -1).
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output int lat, output int bcnt);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    lat   = -1;
    bcnt  = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int lat;
    int bcnt;
    run_op(v.op, v.a, v.b, lat, bcnt);
    chk({tag, " hi"}, hi, v.ehi);
    chk({tag, " lo"}, lo, v.elo);
    chk({tag, " divByZero"}, {31'b0, divByZero}, {31'b0, v.edbz});
    chk({tag, " done_cycle"}, 32'(lat), 32'(v.elat));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(v.ebusy));
  endtask

  initial begin
    int done_cnt;
    vec_t v;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 34};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 34};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 34};
    vecs[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 35, 34};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 34};
    vecs[6]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1,  2,  1};
    vecs[7]  = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 35, 34};
    vecs[8]  = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 35, 34};
    vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35, 34};
    vecs[10] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 35, 34};
    vecs[11] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1,  2,  1};
    vecs[12] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 35, 34};

    rstN = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hiWe = 1'b0; loWe = 1'b0; wrData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset divByZero", {31'b0, divByZero}, 32'h0);
    chk("reset state", {30'b0, dbgState}, {30'b0, ST_IDLE});
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // vector table, each start issued in the previous op's done cycle
    for (int i = 0; i < 13; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // MTHI / MTLO while idle
    hiWe = 1'b1; wrData = 32'h0000_ABCD;
    @(posedge clk); #1;
    hiWe = 1'b0; loWe = 1'b1; wrData = 32'h0000_1234;
    @(posedge clk); #1;
    loWe = 1'b0;
    chk("mthi hi", hi, 32'h0000_ABCD);
    chk("mtlo lo", lo, 32'h0000_1234);

    // MULT aborted by flush in cycle 10; start/hiWe in the busy window dropped
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush busy_c1", {31'b0, busy}, 32'h1);
    for (int n = 2; n <= 9; n++) begin
      @(posedge clk); #1;
      start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
      hiWe = 1'b1; wrData = 32'h0000_DEAD;
    end
    @(posedge clk); #1;
    start = 1'b0; hiWe = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy_c11", {31'b0, busy}, 32'h0);
    chk("flush done_c11", {31'b0, done}, 32'h0);
    chk("flush state_c11", {30'b0, dbgState}, {30'b0, ST_IDLE});
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("flush no_done", 32'(done_cnt), 32'h0);
    chk("flush hi_kept", hi, 32'h0000_ABCD);
    chk("flush lo_kept", lo, 32'h0000_1234);

    // reset in cycle 20 of a DIV
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    chk("rst busy_before", {31'b0, busy}, 32'h1);
    rstN = 1'b0;
    #1;
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("rst idle_after", {30'b0, dbgState}, {30'b0, ST_IDLE});

    // back-to-back: second start in the first op's done cycle
    v = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 35, 34};
    apply_vec("b2b first", v);
    v = '{2'b01, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0, 35, 34};
    apply_vec("b2b second", v);
    @(posedge clk); #1;
    chk("b2b done_pulse_width", {31'b0, done}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
